// File: rtl/mycpu_pkg.sv
// mycpu shared types: function-select codes, opcodes, control FSM states,
// write-back source select and instruction field positions.
// No ports; imported by the control sequencer and its decoder.
package mycpu_pkg;

  // Function-unit select codes. Unassigned codes pass through to the fu as-is.
  typedef enum logic [3:0] {
    FS_MOVA = 4'h0,
    FS_FINC = 4'h1,
    FS_FDEC = 4'h2,
    FS_FNOT = 4'h3,
    FS_FAND = 4'h4,
    FS_FADD = 4'h5,
    FS_FSUB = 4'h6,
    FS_FOR  = 4'h7,
    FS_FXOR = 4'h8,
    FS_FSHL = 4'h9,
    FS_FSHR = 4'hA,
    FS_FMUL = 4'hB
  } fs_t;

  typedef enum logic [2:0] {
    OP_ALU  = 3'b000,
    OP_LDI  = 3'b001,
    OP_LD   = 3'b010,
    OP_ST   = 3'b011,
    OP_BRZ  = 3'b100,
    OP_BRN  = 3'b101,
    OP_JMP  = 3'b110,
    OP_HALT = 3'b111
  } op_t;

  typedef enum logic [2:0] {
    ST_RESET,
    ST_FETCH,
    ST_EXEC,
    ST_MEM,
    ST_HALTED
  } ctrl_state_t;

  typedef enum logic [1:0] {
    WB_FU  = 2'd0,
    WB_MEM = 2'd1,
    WB_IMM = 2'd2
  } wb_sel_t;

  // Instruction field positions
  localparam int OP_MSB     = 15;
  localparam int OP_LSB     = 13;
  localparam int FS_MSB     = 12;
  localparam int FS_LSB     = 9;
  localparam int DR_MSB     = 8;
  localparam int DR_LSB     = 6;
  localparam int SA_MSB     = 5;
  localparam int SA_LSB     = 3;
  localparam int SB_MSB     = 2;
  localparam int SB_LSB     = 0;
  localparam int LDI_DR_MSB = 12;
  localparam int LDI_DR_LSB = 10;
  localparam int IMM_MSB    = 9;
  localparam int OFF_MSB    = 7;

endpackage

// File: rtl/mycpu_ctrl_decode.sv
// Combinational instruction decoder: splits IR into opcode and fields.
// Ports: ir in; op, fs, dr, sa, sb, imm (zero-extended), off (sign-extended) out.
// Zero latency, no flow control.
module mycpu_ctrl_decode
  import mycpu_pkg::*;
(
  input  logic [15:0] ir,
  output logic [2:0]  op,
  output logic [3:0]  fs,
  output logic [2:0]  dr,
  output logic [2:0]  sa,
  output logic [2:0]  sb,
  output logic [15:0] imm,
  output logic [15:0] off
);

  assign op  = ir[OP_MSB:OP_LSB];
  assign fs  = ir[FS_MSB:FS_LSB];
  assign sa  = ir[SA_MSB:SA_LSB];
  assign sb  = ir[SB_MSB:SB_LSB];
  // LDI keeps its destination in the upper field to leave room for a 10-bit immediate
  assign dr  = (op == OP_LDI) ? ir[LDI_DR_MSB:LDI_DR_LSB] : ir[DR_MSB:DR_LSB];
  assign imm = {6'b0, ir[IMM_MSB:0]};
  assign off = {{8{ir[OFF_MSB]}}, ir[OFF_MSB:0]};

endmodule

// File: rtl/mycpu_ctrl.sv
// mycpu control sequencer: fetch/decode/execute FSM driving fu select and regfile controls.
// Ports: clk/rst; mem_* request/ack port; fs_out, z_in/n_in to fu; a_in/b_in, rf_* , wb_sel,
// imm_out to datapath; pc_out, halted status. 2 cycles per ALU/LDI/branch, 3 per LD/ST,
// plus one per memory wait cycle; mem_addr/mem_we/mem_wdata hold while a request awaits ack.
module mycpu_ctrl
  import mycpu_pkg::*;
#(
  parameter logic [15:0] RST_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic [3:0]  fs_out,
  input  logic        z_in,
  input  logic        n_in,
  input  logic [15:0] a_in,
  input  logic [15:0] b_in,
  output logic [2:0]  rf_sa,
  output logic [2:0]  rf_sb,
  output logic [2:0]  rf_dr,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic [15:0] imm_out,
  output logic [15:0] pc_out,
  output logic        halted
);

  ctrl_state_t state, state_nxt;
  logic [15:0] pc, ir;
  logic        zf, nf;
  logic [15:0] mar, mdr;   // data-access address/data, captured in EXEC so they hold through waits

  logic [2:0]  op_raw;
  op_t         op;
  logic [3:0]  fs_f;
  logic [2:0]  dr_f, sa_f, sb_f;
  logic [15:0] imm_f, off_f;

  mycpu_ctrl_decode u_decode (
    .ir  (ir),
    .op  (op_raw),
    .fs  (fs_f),
    .dr  (dr_f),
    .sa  (sa_f),
    .sb  (sb_f),
    .imm (imm_f),
    .off (off_f)
  );

  assign op = op_t'(op_raw);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_RESET;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RESET:  state_nxt = ST_FETCH;
      ST_FETCH:  if (mem_ack) state_nxt = ST_EXEC;
      ST_EXEC: begin
        case (op)
          OP_LD, OP_ST: state_nxt = ST_MEM;
          OP_HALT:      state_nxt = ST_HALTED;
          default:      state_nxt = ST_FETCH;
        endcase
      end
      ST_MEM:    if (mem_ack) state_nxt = ST_FETCH;
      ST_HALTED: state_nxt = ST_HALTED;
      default:   state_nxt = ST_RESET;
    endcase
  end

  // PC, IR, flags and data-access registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pc  <= RST_PC;
      ir  <= 16'h0000;
      zf  <= 1'b0;
      nf  <= 1'b0;
      mar <= 16'h0000;
      mdr <= 16'h0000;
    end else begin
      if (state == ST_FETCH && mem_ack) begin
        ir <= mem_rdata;
        pc <= pc + 16'd1;
      end
      if (state == ST_EXEC) begin
        case (op)
          OP_ALU: begin
            zf <= z_in;
            nf <= n_in;
          end
          // pc already points past the branch, so the offset is relative to the next instruction
          OP_BRZ: if (zf) pc <= pc + off_f;
          OP_BRN: if (nf) pc <= pc + off_f;
          OP_JMP: pc <= a_in;
          OP_LD:  mar <= a_in;
          OP_ST: begin
            mar <= a_in;
            mdr <= b_in;
          end
          default: ;
        endcase
      end
    end
  end

  // Output logic
  always_comb begin
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_addr = pc;
    rf_we    = 1'b0;
    wb_sel   = WB_FU;
    fs_out   = FS_MOVA;
    halted   = 1'b0;
    case (state)
      ST_FETCH: mem_req = 1'b1;
      ST_EXEC: begin
        if (op == OP_ALU) begin
          fs_out = fs_f;
          rf_we  = 1'b1;
        end else if (op == OP_LDI) begin
          rf_we  = 1'b1;
          wb_sel = WB_IMM;
        end
      end
      ST_MEM: begin
        mem_req  = 1'b1;
        mem_addr = mar;
        mem_we   = (op == OP_ST);
        if (op == OP_LD && mem_ack) begin
          rf_we  = 1'b1;
          wb_sel = WB_MEM;
        end
      end
      ST_HALTED: halted = 1'b1;
      default: ;
    endcase
  end

  assign mem_wdata = mdr;
  assign pc_out    = pc;
  assign imm_out   = imm_f;
  assign rf_sa     = sa_f;
  assign rf_sb     = sb_f;
  assign rf_dr     = dr_f;

endmodule

// File: tb/tb_mycpu_ctrl.sv
// Self-checking bench for mycpu_ctrl: table of single-instruction vectors plus
// hand-written LD-wait, ST, HALT, reset-mid-access and PC-wrap sequences.
module tb_mycpu_ctrl;
  import mycpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst, rst2;
  logic [15:0] mem_rdata, a_in, b_in;
  logic        mem_ack, z_in, n_in;

  logic        mem_req, mem_we, rf_we, halted;
  logic [15:0] mem_addr, mem_wdata, imm_out, pc_out;
  logic [3:0]  fs_out;
  logic [2:0]  rf_sa, rf_sb, rf_dr;
  logic [1:0]  wb_sel;

  logic        mem_req_2, mem_we_2, rf_we_2, halted_2;
  logic [15:0] mem_addr_2, mem_wdata_2, imm_out_2, pc_out_2;
  logic [3:0]  fs_out_2;
  logic [2:0]  rf_sa_2, rf_sb_2, rf_dr_2;
  logic [1:0]  wb_sel_2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mycpu_ctrl #(.RST_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .fs_out(fs_out),
    .z_in(z_in), .n_in(n_in), .a_in(a_in), .b_in(b_in), .rf_sa(rf_sa), .rf_sb(rf_sb),
    .rf_dr(rf_dr), .rf_we(rf_we), .wb_sel(wb_sel), .imm_out(imm_out), .pc_out(pc_out),
    .halted(halted)
  );

  mycpu_ctrl #(.RST_PC(16'hFFFF)) dut2 (
    .clk(clk), .rst(rst2), .mem_req(mem_req_2), .mem_we(mem_we_2), .mem_addr(mem_addr_2),
    .mem_wdata(mem_wdata_2), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .fs_out(fs_out_2),
    .z_in(z_in), .n_in(n_in), .a_in(a_in), .b_in(b_in), .rf_sa(rf_sa_2), .rf_sb(rf_sb_2),
    .rf_dr(rf_dr_2), .rf_we(rf_we_2), .wb_sel(wb_sel_2), .imm_out(imm_out_2),
    .pc_out(pc_out_2), .halted(halted_2)
  );

  typedef struct {
    logic [15:0] instr;
    logic        z, n;
    logic [15:0] a;
    logic [3:0]  fs;
    logic [2:0]  dr, sa, sb;
    logic        we;
    logic [1:0]  wb;
    logic [15:0] imm;
    logic [15:0] pc;
    logic [15:0] next_pc;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Zero-wait fetch on dut from FETCH state; returns in EXEC.
  task automatic do_fetch(input logic [15:0] instr, input logic [15:0] exp_pc);
    mem_ack   = 1'b1;
    mem_rdata = instr;
    #1;
    chk("fetch_req",  {15'b0, mem_req}, 16'h1);
    chk("fetch_addr", mem_addr, exp_pc);
    chk("fetch_we",   {15'b0, mem_we}, 16'h0);
    tick();
    mem_ack = 1'b0;
  endtask

  initial begin
    int bad;
    rst = 1'b1; rst2 = 1'b1;
    mem_ack = 1'b0; mem_rdata = '0; z_in = 1'b0; n_in = 1'b0; a_in = '0; b_in = '0;

    //                instr     z     n     a_in      fs    dr    sa    sb    we    wb      imm       pc        next_pc
    vecs[0] = '{16'h0A53, 1'b0, 1'b0, 16'h0000, 4'h5, 3'd1, 3'd2, 3'd3, 1'b1, WB_FU,  16'h0000, 16'h0000, 16'h0001};
    vecs[1] = '{16'h37FF, 1'b0, 1'b0, 16'h0000, 4'h0, 3'd5, 3'd7, 3'd7, 1'b1, WB_IMM, 16'h03FF, 16'h0001, 16'h0002};
    vecs[2] = '{16'h17C1, 1'b1, 1'b0, 16'h0000, 4'hB, 3'd7, 3'd0, 3'd1, 1'b1, WB_FU,  16'h0000, 16'h0002, 16'h0003};
    vecs[3] = '{16'h8004, 1'b0, 1'b0, 16'h0000, 4'h0, 3'd0, 3'd0, 3'd4, 1'b0, WB_FU,  16'h0000, 16'h0003, 16'h0008};
    vecs[4] = '{16'hA004, 1'b0, 1'b0, 16'h0000, 4'h0, 3'd0, 3'd0, 3'd4, 1'b0, WB_FU,  16'h0000, 16'h0008, 16'h0009};
    vecs[5] = '{16'h0C9C, 1'b0, 1'b1, 16'h0000, 4'h6, 3'd2, 3'd3, 3'd4, 1'b1, WB_FU,  16'h0000, 16'h0009, 16'h000A};
    vecs[6] = '{16'hA0F0, 1'b0, 1'b0, 16'h0000, 4'h0, 3'd3, 3'd6, 3'd0, 1'b0, WB_FU,  16'h0000, 16'h000A, 16'hFFFB};
    vecs[7] = '{16'h8010, 1'b0, 1'b0, 16'h0000, 4'h0, 3'd0, 3'd2, 3'd0, 1'b0, WB_FU,  16'h0000, 16'hFFFB, 16'hFFFC};
    vecs[8] = '{16'hC020, 1'b0, 1'b0, 16'h0020, 4'h0, 3'd0, 3'd4, 3'd0, 1'b0, WB_FU,  16'h0000, 16'hFFFC, 16'h0020};

    // Reset values
    tick(); tick();
    chk("rst_mem_req",  {15'b0, mem_req}, 16'h0);
    chk("rst_mem_we",   {15'b0, mem_we}, 16'h0);
    chk("rst_rf_we",    {15'b0, rf_we}, 16'h0);
    chk("rst_halted",   {15'b0, halted}, 16'h0);
    chk("rst_pc",       pc_out, 16'h0000);
    chk("rst_mem_addr", mem_addr, 16'h0000);
    chk("rst_fs",       {12'b0, fs_out}, 16'h0000);
    chk("rst_wb_sel",   {14'b0, wb_sel}, 16'h0000);
    chk("rst_imm",      imm_out, 16'h0000);
    chk("rst_wdata",    mem_wdata, 16'h0000);
    rst = 1'b0;
    tick();

    // Single-instruction vectors, executed back to back
    for (int i = 0; i < 9; i++) begin
      do_fetch(vecs[i].instr, vecs[i].pc);
      z_in = vecs[i].z; n_in = vecs[i].n; a_in = vecs[i].a;
      #1;
      chk($sformatf("v%0d_fs", i), {12'b0, fs_out}, {12'b0, vecs[i].fs});
      chk($sformatf("v%0d_dr", i), {13'b0, rf_dr}, {13'b0, vecs[i].dr});
      chk($sformatf("v%0d_sa", i), {13'b0, rf_sa}, {13'b0, vecs[i].sa});
      chk($sformatf("v%0d_sb", i), {13'b0, rf_sb}, {13'b0, vecs[i].sb});
      chk($sformatf("v%0d_we", i), {15'b0, rf_we}, {15'b0, vecs[i].we});
      chk($sformatf("v%0d_wb", i), {14'b0, wb_sel}, {14'b0, vecs[i].wb});
      chk($sformatf("v%0d_exec_req", i), {15'b0, mem_req}, 16'h0);
      chk($sformatf("v%0d_exec_pc", i), pc_out, vecs[i].pc + 16'd1);
      if (vecs[i].wb == WB_IMM) chk($sformatf("v%0d_imm", i), imm_out, vecs[i].imm);
      tick();
      chk($sformatf("v%0d_next_pc", i), pc_out, vecs[i].next_pc);
      chk($sformatf("v%0d_we_pulse", i), {15'b0, rf_we}, 16'h0);
    end

    // LD with three wait cycles at PC 0x20
    do_fetch(16'h4108, 16'h0020);
    a_in = 16'h1234;
    #1;
    chk("ld_exec_we", {15'b0, rf_we}, 16'h0);
    tick();
    for (int w = 0; w < 3; w++) begin
      chk($sformatf("ld_wait%0d_req", w), {15'b0, mem_req}, 16'h1);
      chk($sformatf("ld_wait%0d_addr", w), mem_addr, 16'h1234);
      chk($sformatf("ld_wait%0d_rfwe", w), {15'b0, rf_we}, 16'h0);
      tick();
    end
    mem_ack = 1'b1; mem_rdata = 16'h5555;
    #1;
    chk("ld_ack_req",  {15'b0, mem_req}, 16'h1);
    chk("ld_ack_addr", mem_addr, 16'h1234);
    chk("ld_ack_we",   {15'b0, mem_we}, 16'h0);
    chk("ld_ack_rfwe", {15'b0, rf_we}, 16'h1);
    chk("ld_ack_wb",   {14'b0, wb_sel}, {14'b0, WB_MEM});
    chk("ld_ack_dr",   {13'b0, rf_dr}, 16'h0004);
    tick();
    mem_ack = 1'b0;
    #1;
    chk("ld_after_rfwe", {15'b0, rf_we}, 16'h0);
    chk("ld_after_addr", mem_addr, 16'h0021);

    // ST, zero-wait
    do_fetch(16'h6013, 16'h0021);
    a_in = 16'h0040; b_in = 16'hBEEF;
    #1;
    chk("st_exec_rfwe", {15'b0, rf_we}, 16'h0);
    tick();
    mem_ack = 1'b1;
    #1;
    chk("st_req",   {15'b0, mem_req}, 16'h1);
    chk("st_we",    {15'b0, mem_we}, 16'h1);
    chk("st_addr",  mem_addr, 16'h0040);
    chk("st_wdata", mem_wdata, 16'hBEEF);
    chk("st_rfwe",  {15'b0, rf_we}, 16'h0);
    tick();
    mem_ack = 1'b0;
    #1;
    chk("st_after_addr", mem_addr, 16'h0022);
    chk("st_after_we",   {15'b0, mem_we}, 16'h0);

    // HALT, then stray acks are ignored for 20 cycles
    do_fetch(16'hE000, 16'h0022);
    #1;
    chk("halt_exec_halted", {15'b0, halted}, 16'h0);
    tick();
    mem_ack = 1'b1;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (halted !== 1'b1 || mem_req !== 1'b0) bad++;
      tick();
    end
    chk("halt_hold_bad_cycles", bad[15:0], 16'h0);
    chk("halt_pc", pc_out, 16'h0023);
    mem_ack = 1'b0;

    // Reset out of HALTED, then reset again in the middle of an LD wait
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("halt_rst_halted", {15'b0, halted}, 16'h0);
    tick();
    do_fetch(16'h4108, 16'h0000);
    a_in = 16'h1234;
    tick();
    chk("midld_req", {15'b0, mem_req}, 16'h1);
    rst = 1'b1; mem_ack = 1'b1;
    tick();
    chk("midld_rst_req",  {15'b0, mem_req}, 16'h0);
    chk("midld_rst_pc",   pc_out, 16'h0000);
    chk("midld_rst_rfwe", {15'b0, rf_we}, 16'h0);
    rst = 1'b0; mem_ack = 1'b0;
    tick();
    chk("refetch_req",  {15'b0, mem_req}, 16'h1);
    chk("refetch_addr", mem_addr, 16'h0000);

    // PC wrap on the RST_PC=0xFFFF instance, then JMP
    rst = 1'b1;
    tick();
    rst2 = 1'b0;
    #1;
    chk("w_rst_addr", mem_addr_2, 16'hFFFF);
    tick();
    mem_ack = 1'b1; mem_rdata = 16'h0A53;
    #1;
    chk("w_fetch_req",  {15'b0, mem_req_2}, 16'h1);
    chk("w_fetch_addr", mem_addr_2, 16'hFFFF);
    tick();
    mem_ack = 1'b0;
    #1;
    chk("w_exec_pc",   pc_out_2, 16'h0000);
    chk("w_exec_rfwe", {15'b0, rf_we_2}, 16'h1);
    tick();
    mem_ack = 1'b1; mem_rdata = 16'hC020;
    #1;
    chk("w_jmp_fetch_addr", mem_addr_2, 16'h0000);
    tick();
    mem_ack = 1'b0; a_in = 16'h0100;
    tick();
    chk("w_jmp_pc", pc_out_2, 16'h0100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
